// File: rtl/kmkz_divide_pipe_pkg.sv
// Shared constants for the Kamikaze-uRV iterative divider: M-extension funct3 codes.
package kmkz_divide_pipe_pkg;

  localparam logic [2:0] FUNC_DIV  = 3'd4;
  localparam logic [2:0] FUNC_DIVU = 3'd5;
  localparam logic [2:0] FUNC_REM  = 3'd6;
  localparam logic [2:0] FUNC_REMU = 3'd7;

endpackage

// File: rtl/kmkz_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, subtract if it fits.
module kmkz_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] r_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] r_next_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // r < d always holds, so the WIDTH+1-bit difference cannot wrap and its MSB is the sign.
  always_comb begin
    shifted  = {r_i, bit_i};
    trial    = shifted - {1'b0, d_i};
    q_bit_o  = ~trial[WIDTH];
    r_next_o = q_bit_o ? trial[WIDTH-1:0] : {r_i[WIDTH-2:0], bit_i};
  end

endmodule

// File: rtl/kmkz_divide_pipe.sv
// Iterative DIV/DIVU/REM/REMU unit for the execute stage, retiring BITS_PER_CYCLE
// quotient bits per cycle, with early completion for divide-by-zero and signed overflow.
module kmkz_divide_pipe
  import kmkz_divide_pipe_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             x_stall_i,
  input  logic             x_kill_i,
  output logic             x_stall_req_o,
  input  logic             d_valid_i,
  input  logic             d_is_divide_i,
  input  logic [WIDTH-1:0] d_rs1_i,
  input  logic [WIDTH-1:0] d_rs2_i,
  input  logic [2:0]       d_fun_i,
  output logic [WIDTH-1:0] x_rd_o
);

  localparam int unsigned N     = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ITER = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [WIDTH-1:0] INT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  logic [1:0]       state_q, state_d;
  logic             is_rem_q, is_rem_d;
  logic             n_sign_q, n_sign_d;
  logic             d_sign_q, d_sign_d;
  logic             special_q, special_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic                      start;
  logic                      op_signed, op_rem;
  logic                      rs1_neg, rs2_neg;
  logic                      div_zero, sgn_ovf;
  logic [WIDTH-1:0]          result;
  logic [WIDTH-1:0]          rem_step;
  logic [BITS_PER_CYCLE-1:0] q_bits;

  // Decode of the instruction presented by the decode stage.
  always_comb begin
    start     = !x_stall_i && !x_kill_i && d_valid_i && d_is_divide_i;
    op_signed = (d_fun_i == FUNC_DIV) || (d_fun_i == FUNC_REM);
    op_rem    = (d_fun_i == FUNC_REM) || (d_fun_i == FUNC_REMU);
    rs1_neg   = op_signed & d_rs1_i[WIDTH-1];
    rs2_neg   = op_signed & d_rs2_i[WIDTH-1];
    div_zero  = (d_rs2_i == '0);
    sgn_ovf   = op_signed && (d_rs1_i == INT_MIN) && (d_rs2_i == '1);
  end

  // Chain of restoring steps; stage k consumes dividend bit WIDTH-1-k (MSB first).
  for (genvar k = 0; k < BITS_PER_CYCLE; k++) begin : g_step
    logic [WIDTH-1:0] r_in;
    logic [WIDTH-1:0] r_out;
    if (k == 0) begin : g_first
      assign r_in = rem_q;
    end else begin : g_next
      assign r_in = g_step[k-1].r_out;
    end
    kmkz_div_step #(.WIDTH(WIDTH)) u_step (
      .r_i      (r_in),
      .bit_i    (dvd_q[WIDTH-1-k]),
      .d_i      (dvs_q),
      .r_next_o (r_out),
      .q_bit_o  (q_bits[BITS_PER_CYCLE-1-k])
    );
  end
  assign rem_step = g_step[BITS_PER_CYCLE-1].r_out;

  // Sign correction; special-case results bypass it.
  always_comb begin
    if (special_q) begin
      result = is_rem_q ? rem_q : quo_q;
    end else if (is_rem_q) begin
      result = n_sign_q ? -rem_q : rem_q;
    end else begin
      result = (n_sign_q ^ d_sign_q) ? -quo_q : quo_q;
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (div_zero || sgn_ovf) ? ST_FIX : ST_ITER;
        end
      end
      ST_ITER: begin
        if (x_kill_i) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        state_d = x_kill_i ? ST_IDLE : ST_DONE;
      end
      ST_DONE: begin
        if (x_kill_i || !x_stall_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values and stall request.
  always_comb begin
    is_rem_d      = is_rem_q;
    n_sign_d      = n_sign_q;
    d_sign_d      = d_sign_q;
    special_d     = special_q;
    dvd_d         = dvd_q;
    dvs_d         = dvs_q;
    quo_d         = quo_q;
    rem_d         = rem_q;
    cnt_d         = cnt_q;
    rd_d          = rd_q;
    x_stall_req_o = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          x_stall_req_o = 1'b1;
          is_rem_d      = op_rem;
          n_sign_d      = rs1_neg;
          d_sign_d      = rs2_neg;
          special_d     = div_zero || sgn_ovf;
          dvd_d         = rs1_neg ? -d_rs1_i : d_rs1_i;
          dvs_d         = rs2_neg ? -d_rs2_i : d_rs2_i;
          cnt_d         = '0;
          if (div_zero) begin
            quo_d = '1;
            rem_d = d_rs1_i;
          end else if (sgn_ovf) begin
            quo_d = d_rs1_i;
            rem_d = '0;
          end else begin
            quo_d = '0;
            rem_d = '0;
          end
        end
      end
      ST_ITER: begin
        x_stall_req_o = 1'b1;
        dvd_d         = dvd_q << BITS_PER_CYCLE;
        quo_d         = {quo_q[WIDTH-1-BITS_PER_CYCLE:0], q_bits};
        rem_d         = rem_step;
        cnt_d         = cnt_q + CNT_W'(1);
      end
      ST_FIX: begin
        x_stall_req_o = 1'b1;
        if (!x_kill_i) begin
          rd_d = result;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      is_rem_q  <= 1'b0;
      n_sign_q  <= 1'b0;
      d_sign_q  <= 1'b0;
      special_q <= 1'b0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      rd_q      <= '0;
    end else begin
      is_rem_q  <= is_rem_d;
      n_sign_q  <= n_sign_d;
      d_sign_q  <= d_sign_d;
      special_q <= special_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
    end
  end

  assign x_rd_o = rd_q;

endmodule

// File: tb/tb_kmkz_divide_pipe.sv
// Directed bench for kmkz_divide_pipe: a 32-bit/1-bit-per-cycle and a 16-bit/4-bit-per-cycle instance.
module tb_kmkz_divide_pipe;
  import kmkz_divide_pipe_pkg::*;

  logic clk = 1'b0;
  logic rst_n, rst16_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  logic        s32, k32, v32, dv32, sr32;
  logic [2:0]  f32;
  logic [31:0] a32, b32, rd32;
  logic        s16, k16, v16, dv16, sr16;
  logic [2:0]  f16;
  logic [15:0] a16, b16, rd16;

  kmkz_divide_pipe #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut32 (
    .clk_i(clk), .rst_n_i(rst_n), .x_stall_i(s32), .x_kill_i(k32), .x_stall_req_o(sr32),
    .d_valid_i(v32), .d_is_divide_i(dv32), .d_rs1_i(a32), .d_rs2_i(b32), .d_fun_i(f32),
    .x_rd_o(rd32));

  kmkz_divide_pipe #(.WIDTH(16), .BITS_PER_CYCLE(4)) dut16 (
    .clk_i(clk), .rst_n_i(rst16_n), .x_stall_i(s16), .x_kill_i(k16), .x_stall_req_o(sr16),
    .d_valid_i(v16), .d_is_divide_i(dv16), .d_rs1_i(a16), .d_rs2_i(b16), .d_fun_i(f16),
    .x_rd_o(rd16));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Count stall-request cycles from the current (start) cycle; drops valid after the first edge.
  task automatic wait_done32(output int n);
    n = 0;
    while (sr32 && n < 200) begin
      n++;
      @(posedge clk); #1 v32 = 1'b0; #1;
    end
  endtask

  task automatic wait_done16(output int n);
    n = 0;
    while (sr16 && n < 200) begin
      n++;
      @(posedge clk); #1 v16 = 1'b0; #1;
    end
  endtask

  task automatic do_op32(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_n);
    int n;
    @(negedge clk);
    f32 = f; a32 = a; b32 = b; v32 = 1'b1; dv32 = 1'b1; #1;
    wait_done32(n);
    v32 = 1'b0;
    chk({tag, " stall"}, 32'(n), 32'(exp_n));
    chk(tag, rd32, exp);
    @(posedge clk); #1;
  endtask

  task automatic do_op16(input string tag, input logic [2:0] f, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] exp, input int exp_n);
    int n;
    @(negedge clk);
    f16 = f; a16 = a; b16 = b; v16 = 1'b1; dv16 = 1'b1; #1;
    wait_done16(n);
    v16 = 1'b0;
    chk({tag, " stall"}, 32'(n), 32'(exp_n));
    chk(tag, {16'h0, rd16}, {16'h0, exp});
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; rst16_n = 1'b0;
    s32 = 0; k32 = 0; v32 = 0; dv32 = 0; f32 = '0; a32 = '0; b32 = '0;
    s16 = 0; k16 = 0; v16 = 0; dv16 = 0; f16 = '0; a16 = '0; b16 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1; rst16_n = 1'b1;
    #1;
    chk("reset rd32", rd32, 32'h0);
    chk("reset req32", {31'h0, sr32}, 32'h0);
    chk("reset rd16", {16'h0, rd16}, 32'h0);
    chk("reset req16", {31'h0, sr16}, 32'h0);

    // 32-bit, one quotient bit per cycle
    do_op32("div 100/-7",   FUNC_DIV,  32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 34);
    do_op32("rem -100%7",   FUNC_REM,  32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 34);
    do_op32("remu ffff%10", FUNC_REMU, 32'hFFFFFFFF, 32'd10,       32'd5,        34);
    do_op32("divu ffff/1",  FUNC_DIVU, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 34);
    do_op32("divu min/-1",  FUNC_DIVU, 32'h80000000, 32'hFFFFFFFF, 32'h0,        34);
    do_op32("div ovf",      FUNC_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2);
    do_op32("rem ovf",      FUNC_REM,  32'h80000000, 32'hFFFFFFFF, 32'h0,        2);
    do_op32("divu 42/0",    FUNC_DIVU, 32'd42,       32'd0,        32'hFFFFFFFF, 2);
    do_op32("remu 42/0",    FUNC_REMU, 32'd42,       32'd0,        32'd42,       2);
    do_op32("div -7/0",     FUNC_DIV,  32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 2);
    do_op32("rem -7/0",     FUNC_REM,  32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 2);

    // kill pulsed in cycle 10 of a DIV
    @(negedge clk);
    f32 = FUNC_DIV; a32 = 32'd1000; b32 = 32'd3; v32 = 1'b1; dv32 = 1'b1; #1;
    chk("kill start req", {31'h0, sr32}, 32'h1);
    @(posedge clk); #1 v32 = 1'b0;
    repeat (9) @(posedge clk);
    #1 k32 = 1'b1; #1;
    chk("kill cycle req", {31'h0, sr32}, 32'h1);
    @(posedge clk); #1 k32 = 1'b0; #1;
    chk("kill idle req", {31'h0, sr32}, 32'h0);
    chk("kill rd hold", rd32, 32'hFFFFFFF9);
    do_op32("div 7/2 after kill", FUNC_DIV, 32'd7, 32'd2, 32'd3, 34);

    // stall held in DONE with a pending divide presented
    @(negedge clk);
    f32 = FUNC_DIVU; a32 = 32'd100; b32 = 32'd7; v32 = 1'b1; dv32 = 1'b1; #1;
    wait_done32(n);
    chk("divu 100/7 stall", 32'(n), 32'd34);
    chk("divu 100/7", rd32, 32'd14);
    s32 = 1'b1; v32 = 1'b1; #1;
    chk("done stalled req", {31'h0, sr32}, 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      chk("done hold rd", rd32, 32'd14);
      chk("done hold req", {31'h0, sr32}, 32'h0);
    end
    s32 = 1'b0; #1;
    chk("done start ignored", {31'h0, sr32}, 32'h0);
    @(posedge clk); #1;
    chk("idle restart req", {31'h0, sr32}, 32'h1);
    wait_done32(n);
    v32 = 1'b0;
    chk("restart stall", 32'(n), 32'd34);
    chk("restart rd", rd32, 32'd14);
    @(posedge clk); #1;

    // 16-bit, four quotient bits per cycle
    do_op16("d16 div 1000/-7",  FUNC_DIV,  16'd1000, 16'hFFF9, 16'hFF72, 6);
    do_op16("d16 rem -1000%7",  FUNC_REM,  16'hFC18, 16'd7,    16'hFFFA, 6);
    do_op16("d16 divu ffff/ff", FUNC_DIVU, 16'hFFFF, 16'h00FF, 16'h0101, 6);
    do_op16("d16 remu ffff%1k", FUNC_REMU, 16'hFFFF, 16'h1000, 16'h0FFF, 6);
    do_op16("d16 div ovf",      FUNC_DIV,  16'h8000, 16'hFFFF, 16'h8000, 2);
    do_op16("d16 rem ovf",      FUNC_REM,  16'h8000, 16'hFFFF, 16'h0000, 2);
    do_op16("d16 divu 5/0",     FUNC_DIVU, 16'd5,    16'd0,    16'hFFFF, 2);
    do_op16("d16 remu 5/0",     FUNC_REMU, 16'd5,    16'd0,    16'd5,    2);
    do_op16("d16 div min/2",    FUNC_DIV,  16'h8000, 16'd2,    16'hC000, 6);

    // asynchronous reset in the middle of ITER
    @(negedge clk);
    f16 = FUNC_DIVU; a16 = 16'd1000; b16 = 16'd3; v16 = 1'b1; dv16 = 1'b1; #1;
    @(posedge clk); #1 v16 = 1'b0;
    @(posedge clk); #3 rst16_n = 1'b0; #1;
    chk("d16 async rst rd", {16'h0, rd16}, 32'h0);
    chk("d16 async rst req", {31'h0, sr16}, 32'h0);
    @(negedge clk); rst16_n = 1'b1;
    @(posedge clk); #1;
    do_op16("d16 divu 100/7", FUNC_DIVU, 16'd100, 16'd7, 16'd14, 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
